// File: rtl/cla_seq_pkg.sv
// Shared types for the multi-word CLA sequencer.
// State encoding and index-width helper.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  function automatic int idx_w(input int words);
    return (words <= 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/carry_look_ahead_adder.sv
// N-bit carry look-ahead adder, purely combinational.
// Each carry is a flat sum of generate/propagate terms.
module carry_look_ahead_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         C_in,
  output logic [N-1:0] S,
  output logic         C_out
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign g = A & B;
  assign p = A ^ B;

  // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i:0]C_in
  always_comb begin
    logic acc;
    logic pp;
    c    = '0;
    c[0] = C_in;
    for (int i = 0; i < N; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & C_in);
    end
  end

  assign S     = p ^ c[N-1:0];
  assign C_out = c[N];

endmodule

// File: rtl/multiword_cla_sequencer.sv
// Wide adder built from one N-bit CLA, one chunk per clock.
// Latches operands, ripples a registered carry, pulses done.
module multiword_cla_sequencer
  import cla_seq_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int WORDS = 4,
  localparam int W     = N * WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         C_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] S,
  output logic         C_out,
  output logic         overflow
);

  localparam int IDX_W = idx_w(WORDS);

  seq_state_t state_q;
  seq_state_t state_d;

  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     s_q;
  logic [W-1:0]     s_nxt;
  logic [IDX_W-1:0] idx_q;
  logic             cr_q;
  logic             c_out_q;
  logic             ovf_q;

  logic [N-1:0] a_ch;
  logic [N-1:0] b_ch;
  logic [N-1:0] sum_ch;
  logic         co_ch;
  logic         last;
  logic         ovf_now;

  assign last = (idx_q == IDX_W'(WORDS - 1));

  // Chunk mux; an out-of-range index selects zero, never X
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_ch = a_q[i*N +: N];
        b_ch = b_q[i*N +: N];
      end
    end
  end

  carry_look_ahead_adder #(
    .N(N)
  ) u_cla (
    .A    (a_ch),
    .B    (b_ch),
    .C_in (cr_q),
    .S    (sum_ch),
    .C_out(co_ch)
  );

  // Merge the fresh chunk sum into the result word
  always_comb begin
    s_nxt = s_q;
    for (int i = 0; i < WORDS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        s_nxt[i*N +: N] = sum_ch;
      end
    end
  end

  assign ovf_now = (a_q[W-1] == b_q[W-1])
                && (sum_ch[N-1] != a_q[W-1]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, chunk walk and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      cr_q    <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            cr_q    <= C_in;
            idx_q   <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end
        RUN: begin
          s_q   <= s_nxt;
          cr_q  <= co_ch;
          idx_q <= last ? '0 : idx_q + IDX_W'(1);
          if (last) begin
            c_out_q <= co_ch;
            ovf_q   <= ovf_now;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign S        = s_q;
  assign C_out    = c_out_q;
  assign overflow = ovf_q;

endmodule
